// File: rtl/ters_sifreleme_if.sv
// ---------------------------------------------------------------------------
// ters_sifreleme_if
//   Bus between the AES-128 inverse cipher core and its surroundings.
//   Signals:
//     sifreli_metin  [127:0]  ciphertext block (byte 0 = bits 127:120 = s(0,0))
//     giris_gecerli           ciphertext valid
//     hazir                   core idle, block can be accepted
//     anahtar_indeks [3:0]    round-key index requested from the key store
//     tur_anahtari   [127:0]  round key for anahtar_indeks (same-cycle return)
//     duz_metin      [127:0]  plaintext, registered
//     cikis_gecerli           one-cycle pulse, duz_metin valid
//   slave  : the core side
//   master : the source / sink / key-store side
// ---------------------------------------------------------------------------
interface ters_sifreleme_if;
    logic [127:0] sifreli_metin;
    logic         giris_gecerli;
    logic         hazir;
    logic [3:0]   anahtar_indeks;
    logic [127:0] tur_anahtari;
    logic [127:0] duz_metin;
    logic         cikis_gecerli;

    modport slave (
        input  sifreli_metin,
        input  giris_gecerli,
        input  tur_anahtari,
        output hazir,
        output anahtar_indeks,
        output duz_metin,
        output cikis_gecerli
    );

    modport master (
        output sifreli_metin,
        output giris_gecerli,
        output tur_anahtari,
        input  hazir,
        input  anahtar_indeks,
        input  duz_metin,
        input  cikis_gecerli
    );
endinterface

// File: rtl/ters_sifreleme_cekirdegi.sv
// ---------------------------------------------------------------------------
// ters_sifreleme_cekirdegi
//   Iterative AES-128 inverse cipher: one inverse round per clock.
//   Ports:
//     clk  : single clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : ters_sifreleme_if.slave (ciphertext in, key index out,
//            round key in, plaintext out with one-cycle valid pulse)
//   Timing: block accepted at the end of cycle T (BOSTA), rounds in
//   T+1..T+9 (TUR), final round in T+10 (SON), pulse in T+11.
//   The state byte at bit offset 127-8k is row k%4, column k/4.
// ---------------------------------------------------------------------------
module ters_sifreleme_cekirdegi #(
    parameter int TUR_SAYISI = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    ters_sifreleme_if.slave       bus
);

    localparam logic [3:0] SON_INDEKS = 4'(TUR_SAYISI);

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        TUR   = 2'd1,
        SON   = 2'd2
    } faz_t;

    // -----------------------------------------------------------------------
    // GF(2^8) helpers, modulus x^8+x^4+x^3+x+1
    // -----------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_carp(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 = a^-1 for a != 0, and 0 -> 0 falls out naturally.
    // 254 = 2+4+8+...+128, so accumulate successive squares.
    function automatic logic [7:0] gf_ters(input logic [7:0] a);
        logic [7:0] kare;
        logic [7:0] sonuc;
        kare  = a;
        sonuc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            kare  = gf_carp(kare, kare);
            sonuc = gf_carp(sonuc, kare);
        end
        return sonuc;
    endfunction

    // Inverse S-box: inverse affine map first, then field inversion.
    function automatic logic [7:0] ters_sbox(input logic [7:0] b);
        logic [7:0] y;
        for (int i = 0; i < 8; i++) begin
            y[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        y = y ^ 8'h05;
        return gf_ters(y);
    endfunction

    // -----------------------------------------------------------------------
    // Round transforms on the 128-bit state
    // -----------------------------------------------------------------------
    function automatic logic [127:0] ters_satir_kaydir(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                // out(r,c) = in(r,(c-r) mod 4): row r rotates right by r
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] ters_alt_bayt(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8 * k -: 8] = ters_sbox(s[127 - 8 * k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] ters_sutun_karistir(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a  [4];
        logic [7:0]   m9 [4];
        logic [7:0]   mb [4];
        logic [7:0]   md [4];
        logic [7:0]   me [4];
        logic [7:0]   x2, x4, x8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127 - 8 * (4 * c + r) -: 8];
                // 9 = 8+1, b = 8+2+1, d = 8+4+1, e = 8+4+2 from one xtime chain
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127 - 8 * (4 * c + 0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            o[127 - 8 * (4 * c + 1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            o[127 - 8 * (4 * c + 2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            o[127 - 8 * (4 * c + 3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return o;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    faz_t         faz_q, faz_d;
    logic [127:0] durum_q, durum_d;
    logic [3:0]   sayac_q, sayac_d;
    logic [127:0] duz_metin_q, duz_metin_d;
    logic         cikis_gecerli_q, cikis_gecerli_d;

    logic [127:0] alt_kaydir;
    logic [127:0] anahtarli;
    logic [127:0] karisik;

    // Shared datapath: TUR uses the mixed result, SON the unmixed one.
    always_comb begin
        alt_kaydir = ters_alt_bayt(ters_satir_kaydir(durum_q));
        anahtarli  = alt_kaydir ^ bus.tur_anahtari;
        karisik    = ters_sutun_karistir(anahtarli);
    end

    // Key index depends only on phase and counter, so it is stable all cycle.
    always_comb begin
        unique case (faz_q)
            BOSTA:   bus.anahtar_indeks = SON_INDEKS;
            TUR:     bus.anahtar_indeks = sayac_q;
            SON:     bus.anahtar_indeks = 4'd0;
            default: bus.anahtar_indeks = SON_INDEKS;
        endcase
    end

    assign bus.hazir         = (faz_q == BOSTA);
    assign bus.duz_metin     = duz_metin_q;
    assign bus.cikis_gecerli = cikis_gecerli_q;

    always_comb begin
        faz_d           = faz_q;
        durum_d         = durum_q;
        sayac_d         = sayac_q;
        duz_metin_d     = duz_metin_q;
        cikis_gecerli_d = 1'b0;
        unique case (faz_q)
            BOSTA: begin
                if (bus.giris_gecerli) begin
                    durum_d = bus.sifreli_metin ^ bus.tur_anahtari;
                    sayac_d = SON_INDEKS - 4'd1;
                    faz_d   = TUR;
                end
            end
            TUR: begin
                durum_d = karisik;
                sayac_d = sayac_q - 4'd1;
                if (sayac_q == 4'd1) begin
                    faz_d = SON;
                end
            end
            SON: begin
                duz_metin_d     = anahtarli;
                cikis_gecerli_d = 1'b1;
                sayac_d         = SON_INDEKS;
                faz_d           = BOSTA;
            end
            default: begin
                faz_d   = BOSTA;
                sayac_d = SON_INDEKS;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            faz_q           <= BOSTA;
            durum_q         <= '0;
            sayac_q         <= SON_INDEKS;
            duz_metin_q     <= '0;
            cikis_gecerli_q <= 1'b0;
        end else begin
            faz_q           <= faz_d;
            durum_q         <= durum_d;
            sayac_q         <= sayac_d;
            duz_metin_q     <= duz_metin_d;
            cikis_gecerli_q <= cikis_gecerli_d;
        end
    end

endmodule

// File: tb/tb_ters_sifreleme_cekirdegi.sv
// ---------------------------------------------------------------------------
// tb_ters_sifreleme_cekirdegi
//   Self-checking bench for the AES-128 inverse cipher core. The reference
//   is a forward AES encryptor plus key expansion; plaintexts are encrypted
//   by the model and the core must recover them.
// ---------------------------------------------------------------------------
module tb_ters_sifreleme_cekirdegi;

    logic clk;
    logic rst;

    ters_sifreleme_if bus ();

    ters_sifreleme_cekirdegi #(.TUR_SAYISI(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [127:0] rk   [0:10];
    logic [7:0]   sbox [0:255];
    int kontroller = 0;
    int hatalar    = 0;
    int darbeler   = 0;

    // Key store: combinational lookup by the requested index.
    assign bus.tur_anahtari = (bus.anahtar_indeks <= 4'd10) ? rk[bus.anahtar_indeks] : 128'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus.cikis_gecerli === 1'b1) darbeler++;
        kontroller++;
        assert (bus.anahtar_indeks <= 4'd10) else begin
            hatalar++;
            $error("FAIL indeks_sinir: got %0d expected <=10", bus.anahtar_indeks);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rol8(input logic [7:0] b, input int k);
        logic [15:0] d;
        d = {b, b};
        return d[15 - k -: 8];
    endfunction

    task automatic sbox_kur();
        logic [7:0] inv, x8;
        for (int x = 0; x < 256; x++) begin
            x8  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic genislet(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp  = {tmp[23:0], tmp[31:24]};
                tmp  = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] sifrele(input logic [127:0] p);
        logic [7:0] a [16];
        logic [7:0] t [16];
        logic [7:0] x0, x1, x2, x3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = p[127 - 8 * i -: 8] ^ rk[0][127 - 8 * i -: 8];
        for (int rn = 1; rn <= 10; rn++) begin
            for (int i = 0; i < 16; i++) a[i] = sbox[a[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4 * c + r] = a[4 * ((c + r) % 4) + r];
            if (rn != 10) begin
                for (int c = 0; c < 4; c++) begin
                    x0 = t[4 * c]; x1 = t[4 * c + 1]; x2 = t[4 * c + 2]; x3 = t[4 * c + 3];
                    t[4 * c + 0] = gmul(8'h02, x0) ^ gmul(8'h03, x1) ^ x2 ^ x3;
                    t[4 * c + 1] = x0 ^ gmul(8'h02, x1) ^ gmul(8'h03, x2) ^ x3;
                    t[4 * c + 2] = x0 ^ x1 ^ gmul(8'h02, x2) ^ gmul(8'h03, x3);
                    t[4 * c + 3] = gmul(8'h03, x0) ^ x1 ^ x2 ^ gmul(8'h02, x3);
                end
            end
            for (int i = 0; i < 16; i++) a[i] = t[i] ^ rk[rn][127 - 8 * i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = a[i];
        return o;
    endfunction

    // ---------------- check helpers ----------------
    task automatic chk(input string ad, input logic [127:0] gozlenen, input logic [127:0] beklenen);
        kontroller++;
        assert (gozlenen === beklenen) else begin
            hatalar++;
            $error("FAIL %s: got %h expected %h", ad, gozlenen, beklenen);
        end
    endtask

    // Waits (bounded) for hazir, presents the block for one accepted edge.
    task automatic kabul(input logic [127:0] ct);
        int t;
        t = 0;
        while (bus.hazir !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("hazir_kabul", 128'(bus.hazir), 128'd1);
        chk("indeks_bosta", 128'(bus.anahtar_indeks), 128'd10);
        bus.sifreli_metin = ct;
        bus.giris_gecerli = 1'b1;
        @(posedge clk);
        #1;
        bus.giris_gecerli = 1'b0;
    endtask

    // Returns at the negedge where cikis_gecerli is seen (n = cycles after accept).
    task automatic bekle(input bit idx_kontrol, input bit gurultu, output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.cikis_gecerli === 1'b1) begin
                n = i;
                bus.giris_gecerli = 1'b0;
                break;
            end
            if (idx_kontrol)
                chk("indeks_sira", 128'(bus.anahtar_indeks), (i <= 9) ? 128'(10 - i) : 128'd0);
            if (gurultu) begin
                bus.sifreli_metin = {$urandom, $urandom, $urandom, $urandom};
                bus.giris_gecerli = 1'($urandom_range(0, 1));
                chk("mesgul_hazir", 128'(bus.hazir), 128'd0);
            end
        end
        chk("gecikme", 128'(n), 128'd11);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] pt, ct, key, pt1, ct1, pt2, ct2;
        int n, d0;

        rst = 1'b1;
        bus.sifreli_metin = '0;
        bus.giris_gecerli = 1'b0;
        for (int r = 0; r < 11; r++) rk[r] = '0;
        sbox_kur();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hazir", 128'(bus.hazir), 128'd1);
        chk("reset_gecerli", 128'(bus.cikis_gecerli), 128'd0);
        chk("reset_duz", bus.duz_metin, 128'h0);
        chk("reset_indeks", 128'(bus.anahtar_indeks), 128'd10);
        rst = 1'b0;
        @(negedge clk);

        // 1: FIPS-197 C.1 with index sequence and latency
        genislet(128'h000102030405060708090a0b0c0d0e0f);
        kabul(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        bekle(1'b1, 1'b0, n);
        chk("c1_duz", bus.duz_metin, 128'h00112233445566778899aabbccddeeff);
        chk("c1_indeks_donus", 128'(bus.anahtar_indeks), 128'd10);
        @(posedge clk); #1;
        chk("c1_tek_darbe", 128'(bus.cikis_gecerli), 128'd0);
        chk("c1_tutma", bus.duz_metin, 128'h00112233445566778899aabbccddeeff);

        // 2: FIPS-197 App. B
        genislet(128'h2b7e151628aed2a6abf7158809cf4f3c);
        kabul(128'h3925841d02dc09fbdc118597196a0b32);
        bekle(1'b0, 1'b0, n);
        chk("b_duz", bus.duz_metin, 128'h3243f6a8885a308d313198a2e0370734);

        // 3: back-to-back, second block accepted in the pulse cycle
        @(posedge clk); #1;
        genislet(128'h000102030405060708090a0b0c0d0e0f);
        kabul(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        bekle(1'b0, 1'b0, n);
        chk("b2b_duz1", bus.duz_metin, 128'h00112233445566778899aabbccddeeff);
        genislet(128'h2b7e151628aed2a6abf7158809cf4f3c);
        kabul(128'h3925841d02dc09fbdc118597196a0b32);
        bekle(1'b0, 1'b0, n);
        chk("b2b_duz2", bus.duz_metin, 128'h3243f6a8885a308d313198a2e0370734);

        // 4: noise on the input while busy is ignored
        @(posedge clk); #1;
        genislet(128'h000102030405060708090a0b0c0d0e0f);
        d0 = darbeler;
        kabul(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        bekle(1'b0, 1'b1, n);
        chk("gurultu_duz", bus.duz_metin, 128'h00112233445566778899aabbccddeeff);
        repeat (3) @(posedge clk);
        #1;
        chk("gurultu_darbe", 128'(darbeler), 128'(d0 + 1));

        // 5: reset at T+5 abandons the block
        key = {$urandom, $urandom, $urandom, $urandom};
        genislet(key);
        pt = {$urandom, $urandom, $urandom, $urandom};
        kabul(sifrele(pt));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        d0 = darbeler;
        @(negedge clk);
        chk("abort_hazir", 128'(bus.hazir), 128'd1);
        chk("abort_duz", bus.duz_metin, 128'h0);
        chk("abort_gecerli", 128'(bus.cikis_gecerli), 128'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_darbe_yok", 128'(darbeler), 128'(d0));
        kabul(sifrele(pt));
        bekle(1'b0, 1'b0, n);
        chk("abort_sonra_duz", bus.duz_metin, pt);

        // rst and giris_gecerli together: nothing loaded
        @(negedge clk);
        rst = 1'b1;
        bus.giris_gecerli = 1'b1;
        bus.sifreli_metin = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        rst = 1'b0;
        bus.giris_gecerli = 1'b0;
        d0 = darbeler;
        chk("rst_kazanir_hazir", 128'(bus.hazir), 128'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("rst_kazanir_darbe", 128'(darbeler), 128'(d0));

        // 6: inverse S-box probe, all-zero round keys
        for (int r = 0; r < 11; r++) rk[r] = '0;
        pt = 128'h000152ff_52ff0001_ff000152_0152ff00;
        kabul(sifrele(pt));
        bekle(1'b0, 1'b0, n);
        chk("sbox_prob", bus.duz_metin, pt);

        // randomized: random keys and plaintexts, some non-schedule keys
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k < 4) begin
                key = {$urandom, $urandom, $urandom, $urandom};
                genislet(key);
            end else begin
                for (int r = 0; r < 11; r++) rk[r] = {$urandom, $urandom, $urandom, $urandom};
            end
            pt = {$urandom, $urandom, $urandom, $urandom};
            if (k == 5) pt = 128'h0;
            kabul(sifrele(pt));
            bekle(1'b0, 1'b0, n);
            chk("rastgele_duz", bus.duz_metin, pt);
        end

        $display("Simulation finished: %0d checks, %0d errors", kontroller, hatalar);
        $finish;
    end

endmodule
